imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_word_assembler.sv | 45 ++++
 rtl/imem_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, memory geometry, halt word.
// Ports: none (package only).
// Optional feature: IMEM_LOADER_CHECKSUM_EN adds the CHECK state used for trailing-checksum validation.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;
  localparam logic [31:0] HLT_WORD = 32'hFFFF_FFFF;

  // Highest word address; writing a non-halt word here means the program overflowed.
  localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_RECV, ST_WRITE, ST_DONE, ST_ERR, ST_CHECK
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_RECV, ST_WRITE, ST_DONE, ST_ERR
  } state_t;
`endif

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes into a big-endian 32-bit word (first byte ends up in bits 31:24).
// Ports: clk/reset (async active-low), clear, load + byte_in, word out, byte count, full flag.
// Latency: a loaded byte is visible in word/cnt the cycle after load; clear has priority over load.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [2:0]  cnt,
  output logic        full
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      // Shifting left means the first byte migrates up to the top slot after four loads.
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = word_q;
  assign cnt  = cnt_q;
  assign full = (cnt_q == 3'd4);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory word by word, holding the CPU until a halt word lands.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_data byte stream, imem_we/addr/wdata
//        write port, cpu_hold, sticky done/error, word_count. Macro IMEM_LOADER_CHECKSUM_EN adds checksum.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                imem_we,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [6:0]          word_count
);

  state_t               state_q, state_d;
  logic [IMEM_AW-1:0]   ptr_q, ptr_d;
  logic [6:0]           wc_q, wc_d;
  logic                 asm_load, asm_clear, asm_full;
  logic [2:0]           asm_cnt;
  logic [31:0]          asm_word;
  logic                 accept;

  word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (asm_clear),
    .load    (asm_load),
    .byte_in (in_data),
    .word    (asm_word),
    .cnt     (asm_cnt),
    .full    (asm_full)
  );

  assign accept = in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wc_d      = wc_q;
    in_ready  = 1'b0;
    asm_load  = 1'b0;
    asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_RECV: begin
        in_ready = 1'b1;
        if (accept) begin
          asm_load = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ in_data;
`endif
          // Decide on the byte being accepted so the write lands in the very next cycle.
          state_d  = (asm_cnt == 3'd3) ? ST_WRITE : ST_RECV;
        end
      end
      ST_WRITE: begin
        asm_clear = 1'b1;
        wc_d      = wc_q + 7'd1;
        if (asm_word == HLT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (ptr_q == LAST_ADDR) begin
          state_d = ST_ERR;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE, ST_ERR: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wc_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // full is always set in WRITE; gating on it guarantees a partial word is never strobed.
  assign imem_we    = (state_q == ST_WRITE) && asm_full;
  assign imem_addr  = ptr_q;
  assign imem_wdata = asm_word;
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);
  assign word_count = wc_q;

endmodule
